// File: rtl/negation_pkg.sv
// negation_pkg: shared mode encoding and constants for the negation pipeline
package negation_pkg;
  typedef enum logic [1:0] {MODE_NOT, MODE_NEG, MODE_ABS, MODE_PASS} mode_t;
  localparam int MAX_W = 1024;
  function automatic logic [MAX_W-1:0] min_neg(input int w);
    return MAX_W'(1) << (w - 1);
  endfunction
endpackage

// File: rtl/negation_pipe_reg.sv
// negation_pipe_reg: one valid/ready register slice that can accept and drain in the same cycle
module negation_pipe_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  // load whenever empty or draining; data only moves on a real transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/negation_unit_pipe.sv
// negation_unit_pipe: two-stage NOT/NEG/ABS/PASS unit with the negate carry split across stages
module negation_unit_pipe
  import negation_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LO_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  mode_t            in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int HI_W = WIDTH - LO_W;
  localparam logic [MAX_W-1:0] MN_FULL = min_neg(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = MN_FULL[WIDTH-1:0];
  logic             neg, inv, carry, ovf_c;
  logic [LO_W-1:0]  lo;
  logic [HI_W-1:0]  hi_cond;
  logic             s1_ready, s1_valid, s2_ready, s2_valid;
  logic             s1_ovf, s1_neg, s1_carry;
  logic [HI_W-1:0]  s1_hi;
  logic [LO_W-1:0]  s1_lo;
  logic [WIDTH-1:0] c;
  // stage 1: condition the operand, finish the low slice and keep its carry
  always_comb begin
    neg = in_mode == MODE_NEG || (in_mode == MODE_ABS && in_a[WIDTH-1]);
    inv = neg || in_mode == MODE_NOT;
    {carry, lo} = {1'b0, inv ? ~in_a[LO_W-1:0] : in_a[LO_W-1:0]} + (LO_W+1)'(neg);
    hi_cond = inv ? ~in_a[WIDTH-1:LO_W] : in_a[WIDTH-1:LO_W];
    ovf_c = (in_mode == MODE_NEG || in_mode == MODE_ABS) && in_a == MIN_NEG;
  end
  negation_pipe_reg #(.DATA_W(WIDTH + 3)) u_s1 (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(s1_ready),
    .in_data({ovf_c, neg, carry, hi_cond, lo}),
    .out_valid(s1_valid),
    .out_ready(s2_ready),
    .out_data({s1_ovf, s1_neg, s1_carry, s1_hi, s1_lo})
  );
  // stage 2: ripple the stored carry into the high slice
  always_comb c = {s1_hi + HI_W'(s1_neg & s1_carry), s1_lo};
  negation_pipe_reg #(.DATA_W(WIDTH + 2)) u_s2 (
    .clk(clk),
    .rst(rst),
    .in_valid(s1_valid),
    .in_ready(s2_ready),
    .in_data({s1_ovf, c == '0, c}),
    .out_valid(s2_valid),
    .out_ready(out_ready),
    .out_data({out_ovf, out_zero, out_c})
  );
  assign in_ready  = s1_ready || rst;
  assign out_valid = s2_valid && !rst;
endmodule

// File: tb/tb_negation_unit_pipe.sv
// tb_negation_unit_pipe: directed vectors with a queue scoreboard and decoupled monitor
module tb_negation_unit_pipe;
  import negation_pkg::*;
  typedef struct {
    logic [63:0] c;
    logic        ovf;
    logic        zero;
    logic        lat;
    int          t;
  } exp_t;
  logic        clk = 0, rst, in_valid, in_ready, out_valid, out_ready, out_ovf, out_zero;
  logic [63:0] in_a, out_c, held_c;
  logic        held;
  mode_t       in_mode;
  int          cyc = 0, checks = 0, errors = 0;
  exp_t        sb[$];

  negation_unit_pipe #(.WIDTH(64), .LO_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .out_ovf(out_ovf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  task automatic send(mode_t m, logic [63:0] a, logic [63:0] c, logic ovf, logic zero, logic lat);
    int n = 0;
    logic acc;
    in_valid = 1;
    in_mode  = m;
    in_a     = a;
    do begin
      #1;
      acc = in_ready;
      if (acc) sb.push_back('{c, ovf, zero, lat, cyc});
      @(negedge clk);
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  // monitor: pops on every output transfer, and checks hold-stability while stalled
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) held = 0;
    else if (out_valid && out_ready) begin
      held = 0;
      if (sb.size() == 0) chk("unexpected_out", out_c, 64'hx);
      else begin
        e = sb.pop_front();
        chk("out_c", out_c, e.c);
        chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
        chk("out_zero", 64'(out_zero), 64'(e.zero));
        if (e.lat) chk("latency", 64'(cyc - e.t), 64'd2);
      end
    end else if (out_valid) begin
      if (held) chk("stall_hold", out_c, held_c);
      held   = 1;
      held_c = out_c;
    end else held = 0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; in_valid = 0; in_mode = MODE_NOT; in_a = 0; out_ready = 1; held = 0; held_c = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_c", out_c, 64'd0);
    chk("rst_flags", {62'd0, out_ovf, out_zero}, 64'd0);
    rst = 0;
    @(negedge clk);
    send(MODE_NEG, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1);
    drain();
    send(MODE_NEG, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000, 0, 0, 1);
    send(MODE_NEG, 64'h0, 64'h0, 0, 1, 1);
    send(MODE_NEG, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 0, 1);
    send(MODE_ABS, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 0, 1);
    send(MODE_ABS, 64'hFFFF_FFFF_FFFF_FFFB, 64'h5, 0, 0, 1);
    send(MODE_ABS, 64'h7, 64'h7, 0, 0, 1);
    send(MODE_NOT, 64'h0F, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 1);
    send(MODE_PASS, 64'h1234, 64'h1234, 0, 0, 1);
    send(MODE_NOT, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 1, 1);
    send(MODE_PASS, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 1);
    drain();
    out_ready = 0;
    send(MODE_NEG, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0);
    send(MODE_NOT, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    #1;
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    fork
      begin
        send(MODE_PASS, 64'h00C0_FFEE, 64'h00C0_FFEE, 0, 0, 0);
        send(MODE_ABS, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 0, 0, 0);
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1;
      end
    join
    drain();
    out_ready = 0;
    send(MODE_PASS, 64'hAAAA, 64'hAAAA, 0, 0, 0);
    send(MODE_PASS, 64'hBBBB, 64'hBBBB, 0, 0, 0);
    rst = 1;
    sb.delete();
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    #1;
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    send(MODE_NEG, 64'h5, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0, 1);
    drain();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
